sys_bus_ctrl: RTL and testbench
===============================

SYS_BUS_CTRL -- requirements
Module: sys_bus_ctrl

Interface
REQ-001 Parameter N_DEV, default 4, number of decoded device channels, legal 1..8.
REQ-002 Parameter BASE[N_DEV] x 16 bits, default {16'h0000,16'h4000,16'h8000,16'h00F0}, region base per channel.
REQ-003 Parameter MASK[N_DEV] x 16 bits, default {16'hC000,16'hC000,16'hC000,16'hFFF0}, compare mask per channel.
REQ-004 Parameter IO_SPACE, N_DEV bits, default 4'b1000, 1 = channel decodes I/O space, 0 = memory space.
REQ-005 Parameter WAIT_ST[N_DEV] x 4 bits, default {0,1,2,0}, fixed wait states per channel.
REQ-006 Parameter TIMEOUT, default 64, maximum WAIT-state cycles before forced termination, legal 2..255.
REQ-007 clk  in  1  system clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 ale  in  1  address latch enable from CPU.
REQ-010 ad  in  8  multiplexed low address/data bus, sampled only when ale=1.
REQ-011 a_hi  in  8  high address byte.
REQ-012 io_mn  in  1  1 = I/O cycle, 0 = memory cycle, sampled with ale.
REQ-013 rdn, wrn  in  1 each  active-low read/write strobes.
REQ-014 dev_wait  in  N_DEV  per-channel device-requested wait extension, active-high.
REQ-015 addr  out  16  latched address.
REQ-016 cs_n  out  N_DEV  active-low one-hot chip selects.
REQ-017 ready  out  1  READY to CPU.
REQ-018 bus_err  out  1  one-cycle error pulse.
REQ-019 err_addr  out  16  address of most recent error.

Function
REQ-020 FSM states SHALL be IDLE, DECODE, WAIT, ACTIVE.
REQ-021 IDLE: ready=1, cs_n all 1; ale=1 at edge k -> addr={a_hi,ad}, io latched, next DECODE.
REQ-022 DECODE (one cycle): hit = lowest i with (addr & MASK[i])==BASE[i] and IO_SPACE[i]==io latched; overlapping regions resolve to lowest index.
REQ-023 DECODE, no hit: bus_err=1 one cycle, err_addr=addr, cs_n all 1, ready=1, next ACTIVE.
REQ-024 DECODE, hit i: cs_n[i]=0 from edge k+1; if WAIT_ST[i]==0 and dev_wait[i]==0 -> ready=1, ACTIVE; else ready=0, wait counter=WAIT_ST[i], timeout counter=0, WAIT.
REQ-025 WAIT: ready=0; wait counter decrements to 0 and holds; exit to ACTIVE with ready=1 when counter==0 and dev_wait[i]==0.
REQ-026 WAIT: timeout counter increments each cycle; reaching TIMEOUT -> bus_err pulse, err_addr=addr, ready=1, ACTIVE, regardless of dev_wait.
REQ-027 ACTIVE: cs_n[i] held low; return to IDLE (cs_n all 1) on first edge where rdn=1 and wrn=1 after at least one strobe low sample.
REQ-028 ale=1 in ACTIVE with both strobes high SHALL start a new cycle (go DECODE, relatch addr); ale in DECODE/WAIT ignored.
REQ-029 At most one cs_n bit low at any time; cs_n, ready, bus_err SHALL be registered outputs.
REQ-030 rdn=0 and wrn=0 simultaneously SHALL be treated as an active strobe; no error.

Reset
REQ-031 On rst=0 at a clock edge: state IDLE, addr=0, cs_n all 1, ready=1, bus_err=0, err_addr=0, counters=0.
REQ-032 Reset mid-cycle (DECODE/WAIT/ACTIVE) SHALL abort the cycle with no bus_err pulse.

Structure
REQ-033 Shared package sys_bus_pkg SHALL hold the state enum, the default BASE/MASK/WAIT_ST constants and the N_DEV maximum.
REQ-034 One sub-module sys_bus_decode (combinational priority address matcher) SHALL be instantiated; FSM and counters stay in sys_bus_ctrl.

Verification
REQ-035 Memory read 16'h0123, ch0 WAIT_ST=0 -> cs_n=4'b1110 at k+1, ready never low, IDLE after rdn rises.
REQ-036 Memory write 16'h8010, ch2 WAIT_ST=2 -> ready low exactly 2 cycles, cs_n=4'b1011 throughout.
REQ-037 I/O read port 16'h00F3 -> cs_n=4'b0111; same address as memory cycle -> ch0 selected.
REQ-038 Memory access 16'hC000 (unmapped) -> bus_err one cycle, err_addr=16'hC000, cs_n all 1, ready 1.
REQ-039 ch1 access with dev_wait[1] held high -> ready low 64 cycles, then bus_err pulse, ready=1.
REQ-040 rst=0 asserted during WAIT of ch2 -> next edge cs_n all 1, ready=1, bus_err never pulses.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// Shared types and default channel map for the system bus controller.
package sys_bus_pkg;

  localparam int unsigned N_DEV_MAX = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WAIT   = 2'd2,
    ACTIVE = 2'd3
  } bus_state_t;

  // Channel 0..3: low memory, mid memory, high memory, I/O ports 0xF0-0xFF.
  localparam logic [15:0] DEF_BASE    [4] = '{16'h0000, 16'h4000, 16'h8000, 16'h00F0};
  localparam logic [15:0] DEF_MASK    [4] = '{16'hC000, 16'hC000, 16'hC000, 16'hFFF0};
  localparam logic [3:0]  DEF_WAIT_ST [4] = '{4'd0, 4'd1, 4'd2, 4'd0};
  localparam logic [3:0]  DEF_IO_SPACE    = 4'b1000;

endpackage

// File: rtl/sys_bus_decode.sv
// Combinational priority address matcher: lowest matching channel wins.
module sys_bus_decode
  import sys_bus_pkg::*;
#(
  parameter int unsigned N_DEV               = 4,
  parameter logic [15:0] BASE     [N_DEV]    = DEF_BASE,
  parameter logic [15:0] MASK     [N_DEV]    = DEF_MASK,
  parameter logic [N_DEV-1:0] IO_SPACE       = DEF_IO_SPACE
) (
  input  logic [15:0]      addr,
  input  logic             io,
  output logic             hit,
  output logic [N_DEV-1:0] sel
);

  // Scan channels in ascending order; first match claims the cycle.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (!hit && ((addr & MASK[i]) == BASE[i]) && (IO_SPACE[i] == io)) begin
        hit    = 1'b1;
        sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_bus_ctrl.sv
// System bus controller: address latch, chip-select decode, wait-state
// insertion with device extension and timeout, error capture.
module sys_bus_ctrl
  import sys_bus_pkg::*;
#(
  parameter int unsigned N_DEV               = 4,
  parameter logic [15:0] BASE     [N_DEV]    = DEF_BASE,
  parameter logic [15:0] MASK     [N_DEV]    = DEF_MASK,
  parameter logic [N_DEV-1:0] IO_SPACE       = DEF_IO_SPACE,
  parameter logic [3:0]  WAIT_ST  [N_DEV]    = DEF_WAIT_ST,
  parameter int unsigned TIMEOUT             = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ale,
  input  logic [7:0]       ad,
  input  logic [7:0]       a_hi,
  input  logic             io_mn,
  input  logic             rdn,
  input  logic             wrn,
  input  logic [N_DEV-1:0] dev_wait,
  output logic [15:0]      addr,
  output logic [N_DEV-1:0] cs_n,
  output logic             ready,
  output logic             bus_err,
  output logic [15:0]      err_addr
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  bus_state_t       state, state_nx;
  logic [15:0]      addr_nx, err_addr_nx;
  logic [N_DEV-1:0] cs_n_nx;
  logic             ready_nx, bus_err_nx;
  logic             io_q, io_nx;
  logic [3:0]       wcnt, wcnt_nx, wcnt_dec;
  logic [7:0]       tcnt, tcnt_nx, tcnt_inc;
  logic             seen, seen_nx;

  logic             hit, hit_dw, cur_dw, strobe, bus_idle;
  logic [N_DEV-1:0] sel;
  logic [3:0]       hit_ws;

  sys_bus_decode #(
    .N_DEV    (N_DEV),
    .BASE     (BASE),
    .MASK     (MASK),
    .IO_SPACE (IO_SPACE)
  ) u_decode (
    .addr (addr),
    .io   (io_q),
    .hit  (hit),
    .sel  (sel)
  );

  assign strobe   = !rdn || !wrn;
  assign bus_idle = rdn && wrn;
  assign hit_dw   = |(dev_wait & sel);
  assign cur_dw   = |(dev_wait & ~cs_n);
  assign wcnt_dec = (wcnt == 4'd0) ? 4'd0 : wcnt - 4'd1;
  assign tcnt_inc = tcnt + 8'd1;

  // Wait-state count of the channel selected by the decoder.
  always_comb begin
    hit_ws = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (sel[i]) hit_ws = hit_ws | WAIT_ST[i];
    end
  end

  // Next-state and next-output logic for the bus cycle FSM.
  always_comb begin
    state_nx    = state;
    addr_nx     = addr;
    io_nx       = io_q;
    cs_n_nx     = cs_n;
    ready_nx    = ready;
    bus_err_nx  = 1'b0;
    err_addr_nx = err_addr;
    wcnt_nx     = wcnt;
    tcnt_nx     = tcnt;
    seen_nx     = seen;
    case (state)
      IDLE: begin
        cs_n_nx  = '1;
        ready_nx = 1'b1;
        seen_nx  = 1'b0;
        if (ale) begin
          addr_nx  = {a_hi, ad};
          io_nx    = io_mn;
          state_nx = DECODE;
        end
      end
      DECODE: begin
        seen_nx = seen | strobe;
        if (!hit) begin
          bus_err_nx  = 1'b1;
          err_addr_nx = addr;
          cs_n_nx     = '1;
          ready_nx    = 1'b1;
          state_nx    = ACTIVE;
        end else begin
          cs_n_nx = ~sel;
          if ((hit_ws == 4'd0) && !hit_dw) begin
            ready_nx = 1'b1;
            state_nx = ACTIVE;
          end else begin
            ready_nx = 1'b0;
            wcnt_nx  = hit_ws;
            tcnt_nx  = '0;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        seen_nx = seen | strobe;
        if (tcnt_inc == TO_LIM) begin
          bus_err_nx  = 1'b1;
          err_addr_nx = addr;
          ready_nx    = 1'b1;
          state_nx    = ACTIVE;
        end else begin
          // Exit is judged on the post-decrement count so that WAIT_ST=n
          // holds READY low for exactly n cycles.
          wcnt_nx = wcnt_dec;
          tcnt_nx = tcnt_inc;
          if ((wcnt_dec == 4'd0) && !cur_dw) begin
            ready_nx = 1'b1;
            state_nx = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (ale && bus_idle) begin
          addr_nx  = {a_hi, ad};
          io_nx    = io_mn;
          seen_nx  = 1'b0;
          cs_n_nx  = '1;
          ready_nx = 1'b1;
          state_nx = DECODE;
        end else if (bus_idle && seen) begin
          cs_n_nx  = '1;
          ready_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          seen_nx = seen | strobe;
        end
      end
      default: begin
        cs_n_nx  = '1;
        ready_nx = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // State, registered outputs and counters with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      addr     <= '0;
      io_q     <= 1'b0;
      cs_n     <= '1;
      ready    <= 1'b1;
      bus_err  <= 1'b0;
      err_addr <= '0;
      wcnt     <= '0;
      tcnt     <= '0;
      seen     <= 1'b0;
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      io_q     <= io_nx;
      cs_n     <= cs_n_nx;
      ready    <= ready_nx;
      bus_err  <= bus_err_nx;
      err_addr <= err_addr_nx;
      wcnt     <= wcnt_nx;
      tcnt     <= tcnt_nx;
      seen     <= seen_nx;
    end
  end

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Directed bench for sys_bus_ctrl with default parameters.
module tb_sys_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst, ale, io_mn, rdn, wrn;
  logic [7:0]  ad, a_hi;
  logic [3:0]  dev_wait;
  logic [15:0] addr, err_addr;
  logic [3:0]  cs_n;
  logic        ready, bus_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  sys_bus_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ale      (ale),
    .ad       (ad),
    .a_hi     (a_hi),
    .io_mn    (io_mn),
    .rdn      (rdn),
    .wrn      (wrn),
    .dev_wait (dev_wait),
    .addr     (addr),
    .cs_n     (cs_n),
    .ready    (ready),
    .bus_err  (bus_err),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic        io;
    logic        wr;
    logic [3:0]  dw;
    logic [3:0]  cs;
    logic        err;
    int unsigned nwait;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_cycle(input logic [15:0] a, input logic io);
    a_hi  = a[15:8];
    ad    = a[7:0];
    io_mn = io;
    ale   = 1'b1;
    step();
    ale   = 1'b0;
  endtask

  // Count cycles with READY low, bounded so a stuck READY cannot hang.
  task automatic count_wait(output int unsigned n);
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned n;
    dev_wait = v.dw;
    start_cycle(v.a, v.io);
    chk("addr_latch", addr, v.a);
    step();
    chk("cs_n_decode", {12'h0, cs_n}, {12'h0, v.cs});
    chk("bus_err_decode", {15'h0, bus_err}, {15'h0, v.err});
    chk("ready_decode", {15'h0, ready}, {15'h0, (v.nwait == 0)});
    if (v.err) chk("err_addr", err_addr, v.a);
    count_wait(n);
    chk("ready_low_cycles", n[15:0], v.nwait[15:0]);
    if (v.wr) wrn = 1'b0; else rdn = 1'b0;
    step();
    chk("cs_n_active", {12'h0, cs_n}, {12'h0, v.cs});
    chk("bus_err_single", {15'h0, bus_err}, 16'h0);
    rdn = 1'b1;
    wrn = 1'b1;
    step();
    chk("cs_n_idle", {12'h0, cs_n}, 16'h000F);
    chk("ready_idle", {15'h0, ready}, 16'h0001);
    dev_wait = '0;
  endtask

  initial begin
    int unsigned n;
    vecs[0]  = '{16'h0123, 1'b0, 1'b0, 4'b0000, 4'b1110, 1'b0, 0};
    vecs[1]  = '{16'h8010, 1'b0, 1'b1, 4'b0000, 4'b1011, 1'b0, 2};
    vecs[2]  = '{16'h00F3, 1'b1, 1'b0, 4'b0000, 4'b0111, 1'b0, 0};
    vecs[3]  = '{16'h00F3, 1'b0, 1'b0, 4'b0000, 4'b1110, 1'b0, 0};
    vecs[4]  = '{16'hC000, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 0};
    vecs[5]  = '{16'h4567, 1'b0, 1'b1, 4'b0000, 4'b1101, 1'b0, 1};
    vecs[6]  = '{16'h0100, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 0};
    vecs[7]  = '{16'h00FF, 1'b1, 1'b1, 4'b0000, 4'b0111, 1'b0, 0};
    vecs[8]  = '{16'hBFFF, 1'b0, 1'b0, 4'b0000, 4'b1011, 1'b0, 2};
    vecs[9]  = '{16'hFFFF, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1, 0};
    vecs[10] = '{16'h0123, 1'b0, 1'b0, 4'b1110, 4'b1110, 1'b0, 0};

    rst = 1'b0; ale = 1'b0; ad = '0; a_hi = '0; io_mn = 1'b0;
    rdn = 1'b1; wrn = 1'b1; dev_wait = '0;
    step();
    step();
    chk("rst_addr", addr, 16'h0000);
    chk("rst_cs_n", {12'h0, cs_n}, 16'h000F);
    chk("rst_ready", {15'h0, ready}, 16'h0001);
    chk("rst_bus_err", {15'h0, bus_err}, 16'h0000);
    chk("rst_err_addr", err_addr, 16'h0000);
    rst = 1'b1;
    step();

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Device-extended wait on a zero-wait-state channel.
    dev_wait = 4'b0001;
    start_cycle(16'h0010, 1'b0);
    step();
    chk("dw_cs_n", {12'h0, cs_n}, 16'h000E);
    chk("dw_ready_k1", {15'h0, ready}, 16'h0000);
    step();
    chk("dw_ready_k2", {15'h0, ready}, 16'h0000);
    dev_wait = 4'b0000;
    step();
    chk("dw_ready_release", {15'h0, ready}, 16'h0001);
    wrn = 1'b0;
    step();
    wrn = 1'b1;
    step();
    chk("dw_idle", {12'h0, cs_n}, 16'h000F);

    // Timeout on ch1 with dev_wait stuck high.
    dev_wait = 4'b0010;
    start_cycle(16'h4000, 1'b0);
    step();
    chk("to_ready_low", {15'h0, ready}, 16'h0000);
    count_wait(n);
    chk("to_cycles", n[15:0], 16'd64);
    chk("to_bus_err", {15'h0, bus_err}, 16'h0001);
    chk("to_err_addr", err_addr, 16'h4000);
    chk("to_cs_n", {12'h0, cs_n}, 16'h000D);
    dev_wait = 4'b0000;
    rdn = 1'b0;
    step();
    chk("to_bus_err_end", {15'h0, bus_err}, 16'h0000);
    rdn = 1'b1;
    step();
    chk("to_idle", {12'h0, cs_n}, 16'h000F);

    // Back-to-back via ale in ACTIVE; ale ignored in WAIT; both strobes low.
    start_cycle(16'h0123, 1'b0);
    step();
    chk("b2b_first_cs", {12'h0, cs_n}, 16'h000E);
    start_cycle(16'h8010, 1'b0);
    chk("b2b_relatch", addr, 16'h8010);
    chk("b2b_cs_gap", {12'h0, cs_n}, 16'h000F);
    step();
    chk("b2b_cs_ch2", {12'h0, cs_n}, 16'h000B);
    start_cycle(16'h0123, 1'b0);
    chk("wait_ale_ignored", addr, 16'h8010);
    chk("wait_ready_low", {15'h0, ready}, 16'h0000);
    rdn = 1'b0;
    wrn = 1'b0;
    step();
    chk("b2b_ready", {15'h0, ready}, 16'h0001);
    step();
    chk("both_strobe_cs", {12'h0, cs_n}, 16'h000B);
    chk("both_strobe_no_err", {15'h0, bus_err}, 16'h0000);
    rdn = 1'b1;
    wrn = 1'b1;
    step();
    chk("b2b_idle", {12'h0, cs_n}, 16'h000F);

    // Reset during WAIT of ch2 aborts without an error pulse.
    start_cycle(16'h8000, 1'b0);
    step();
    chk("rw_ready_low", {15'h0, ready}, 16'h0000);
    rst = 1'b0;
    step();
    chk("rw_cs_n", {12'h0, cs_n}, 16'h000F);
    chk("rw_ready", {15'h0, ready}, 16'h0001);
    chk("rw_bus_err", {15'h0, bus_err}, 16'h0000);
    chk("rw_addr", addr, 16'h0000);
    chk("rw_err_addr", err_addr, 16'h0000);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_post_bus_err", {15'h0, bus_err}, 16'h0000);
      chk("rw_post_cs_n", {12'h0, cs_n}, 16'h000F);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
